// File: rtl/dau_token_decoder_pkg.sv
// Shared symbol encodings, BCDU opcodes, error codes and decode helpers for the
// RPN calculator token decoder.
package dau_token_decoder_pkg;

    localparam int DAU_SYM_WIDTH = 5;

    // Digits 0-9 are encoded as their own value; everything else sits above.
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_COMMA     = 5'd10;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_PLUS      = 5'd11;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_MINUS     = 5'd12;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_MUL       = 5'd13;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_DIV       = 5'd14;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_SEPARATOR = 5'd15;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_RESULT    = 5'd16;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_RESET     = 5'd17;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_NEW_LINE  = 5'd18;
    localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_INVALID   = 5'd31;

    localparam logic [3:0] BCDU_OP_NOP = 4'd0;
    localparam logic [3:0] BCDU_OP_SHL = 4'd1;
    localparam logic [3:0] BCDU_OP_CLR = 4'd2;

    localparam logic [1:0] DAU_ERR_SYNTAX    = 2'd0;
    localparam logic [1:0] DAU_ERR_DIGIT_OVF = 2'd1;
    localparam logic [1:0] DAU_ERR_STACK_OVF = 2'd2;
    localparam logic [1:0] DAU_ERR_STACK_UNF = 2'd3;

    localparam int DAU_OPSTART_PRINT = 0;
    localparam int DAU_OPSTART_ADD   = 1;
    localparam int DAU_OPSTART_SUB   = 2;
    localparam int DAU_OPSTART_MUL   = 3;
    localparam int DAU_OPSTART_DIV   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_CLEAR,
        ST_FLUSH
    } dau_state_t;

    function automatic logic dau_is_digit(input logic [DAU_SYM_WIDTH-1:0] s);
        return s <= 5'd9;
    endfunction

    function automatic logic dau_is_operator(input logic [DAU_SYM_WIDTH-1:0] s);
        return (s == DAU_SYM_PLUS) || (s == DAU_SYM_MINUS) ||
               (s == DAU_SYM_MUL)  || (s == DAU_SYM_DIV);
    endfunction

    function automatic logic [4:0] dau_opstart_onehot(input logic [DAU_SYM_WIDTH-1:0] s);
        logic [4:0] v;
        v = '0;
        case (s)
            DAU_SYM_PLUS:  v[DAU_OPSTART_ADD] = 1'b1;
            DAU_SYM_MINUS: v[DAU_OPSTART_SUB] = 1'b1;
            DAU_SYM_MUL:   v[DAU_OPSTART_MUL] = 1'b1;
            DAU_SYM_DIV:   v[DAU_OPSTART_DIV] = 1'b1;
            default:       v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dau_instr_slot.sv
// Single-entry valid/ready output register; the held word stays stable until
// the consumer accepts it, and a new load may coincide with that acceptance.
module dau_instr_slot #(
    parameter int            W         = 15,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_free
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign o_valid = valid_reg;
    assign o_data  = data_reg;
    assign o_free  = !valid_reg || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg <= 1'b0;
            data_reg  <= RESET_VAL;
        end else if (i_load) begin
            valid_reg <= 1'b1;
            data_reg  <= i_data;
        end else if (i_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/dau_token_decoder.sv
// RPN symbol stream decoder: tracks operand entry and the stack pointer, emits
// BCDU instructions, starts operations and reports coded errors.
module dau_token_decoder
    import dau_token_decoder_pkg::*;
#(
    parameter int  NUM_DIGITS  = 8,
    parameter int  STACK_DEPTH = 7,
    localparam int PTR_W       = $clog2(STACK_DEPTH + 1),
    localparam int INSTR_W     = 12 + PTR_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [DAU_SYM_WIDTH-1:0] i_symbol,
    output logic                     o_ready,
    output logic                     o_instr_valid,
    output logic [INSTR_W-1:0]       o_instr,
    input  logic                     i_instr_ready,
    input  logic                     i_operation_done,
    output logic [4:0]               o_op_start,
    output logic                     o_loopback_en,
    output logic [DAU_SYM_WIDTH-1:0] o_loopback_symbol,
    output logic                     o_comma_inc,
    output logic                     o_comma_clr,
    output logic                     o_sign_set,
    output logic                     o_sign_clr,
    output logic [PTR_W-1:0]         o_stack_ptr,
    output logic                     o_error,
    output logic [1:0]               o_error_code
);

    localparam int                 CNT_W     = $clog2(NUM_DIGITS + 1);
    localparam logic [PTR_W-1:0]   PTR_MAX   = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]   PTR_TWO   = PTR_W'(2);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(NUM_DIGITS);
    localparam logic [INSTR_W-1:0] INSTR_NOP = {BCDU_OP_NOP, {(INSTR_W-4){1'b0}}};

    dau_state_t               state_reg, state_next;
    logic [DAU_SYM_WIDTH-1:0] sym_reg, sym_next;
    logic [CNT_W-1:0]         count_reg, count_next;
    logic                     got_comma_reg, got_comma_next;
    logic                     got_sign_reg, got_sign_next;
    logic [PTR_W-1:0]         ptr_reg, ptr_next;
    logic                     clr_issued_reg, clr_issued_next;
    logic                     lb_en_reg, lb_en_next;
    logic [DAU_SYM_WIDTH-1:0] lb_sym_reg, lb_sym_next;
    logic [4:0]               op_start_reg, op_start_next;
    logic                     comma_inc_reg, comma_inc_next;
    logic                     comma_clr_reg, comma_clr_next;
    logic                     sign_set_reg, sign_set_next;
    logic                     sign_clr_reg, sign_clr_next;
    logic                     err_reg, err_next;
    logic [1:0]               err_code_reg, err_code_next;

    logic                     instr_load;
    logic [INSTR_W-1:0]       instr_data;
    logic                     slot_free;
    logic                     accept;
    logic                     err_hit;
    logic [1:0]               err_sel;

    dau_instr_slot #(
        .W         (INSTR_W),
        .RESET_VAL (INSTR_NOP)
    ) u_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (instr_load),
        .i_data  (instr_data),
        .i_ready (i_instr_ready),
        .o_valid (o_instr_valid),
        .o_data  (o_instr),
        .o_free  (slot_free)
    );

    assign o_ready = (state_reg == ST_IDLE) && slot_free;
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_next      = state_reg;
        sym_next        = sym_reg;
        count_next      = count_reg;
        got_comma_next  = got_comma_reg;
        got_sign_next   = got_sign_reg;
        ptr_next        = ptr_reg;
        clr_issued_next = clr_issued_reg;
        instr_load      = 1'b0;
        instr_data      = INSTR_NOP;
        lb_en_next      = 1'b0;
        lb_sym_next     = lb_sym_reg;
        op_start_next   = '0;
        comma_inc_next  = 1'b0;
        comma_clr_next  = 1'b0;
        sign_set_next   = 1'b0;
        sign_clr_next   = 1'b0;
        err_hit         = 1'b0;
        err_sel         = DAU_ERR_SYNTAX;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (dau_is_digit(i_symbol)) begin
                        if (sym_reg == DAU_SYM_RESULT) begin
                            err_hit = 1'b1;
                        end else if (ptr_reg == PTR_MAX) begin
                            err_hit = 1'b1;
                            err_sel = DAU_ERR_STACK_OVF;
                        end else if (count_reg == CNT_MAX) begin
                            err_hit = 1'b1;
                            err_sel = DAU_ERR_DIGIT_OVF;
                        end else begin
                            instr_load     = 1'b1;
                            instr_data     = {BCDU_OP_SHL, ptr_reg, 4'b1100, i_symbol[3:0]};
                            lb_en_next     = 1'b1;
                            lb_sym_next    = i_symbol;
                            count_next     = count_reg + CNT_W'(1);
                            comma_inc_next = got_comma_reg;
                            sym_next       = i_symbol;
                            if (sym_reg == DAU_SYM_MINUS && !got_sign_reg) begin
                                sign_set_next = 1'b1;
                                got_sign_next = 1'b1;
                            end
                        end
                    end else begin
                        case (i_symbol)
                            DAU_SYM_COMMA: begin
                                if (got_comma_reg) begin
                                    err_hit = 1'b1;
                                end else begin
                                    lb_en_next     = 1'b1;
                                    lb_sym_next    = i_symbol;
                                    got_comma_next = 1'b1;
                                    sym_next       = i_symbol;
                                    if (sym_reg == DAU_SYM_MINUS && !got_sign_reg) begin
                                        sign_set_next = 1'b1;
                                        got_sign_next = 1'b1;
                                    end
                                end
                            end
                            DAU_SYM_PLUS, DAU_SYM_MINUS: begin
                                if (sym_reg == DAU_SYM_INVALID || sym_reg == DAU_SYM_SEPARATOR) begin
                                    lb_en_next  = 1'b1;
                                    lb_sym_next = i_symbol;
                                    sym_next    = i_symbol;
                                end else begin
                                    err_hit = 1'b1;
                                end
                            end
                            DAU_SYM_MUL, DAU_SYM_DIV: begin
                                if (sym_reg == DAU_SYM_SEPARATOR) begin
                                    lb_en_next  = 1'b1;
                                    lb_sym_next = i_symbol;
                                    sym_next    = i_symbol;
                                end else begin
                                    err_hit = 1'b1;
                                end
                            end
                            DAU_SYM_SEPARATOR: begin
                                if (sym_reg == DAU_SYM_SEPARATOR || sym_reg == DAU_SYM_INVALID) begin
                                    err_hit = 1'b1;
                                end else if (dau_is_operator(sym_reg)) begin
                                    // Even a rejected operator closes the expression.
                                    sym_next = DAU_SYM_SEPARATOR;
                                    if (ptr_reg >= PTR_TWO) begin
                                        lb_en_next     = 1'b1;
                                        lb_sym_next    = i_symbol;
                                        count_next     = '0;
                                        got_comma_next = 1'b0;
                                        got_sign_next  = 1'b0;
                                        op_start_next  = dau_opstart_onehot(sym_reg);
                                        ptr_next       = ptr_reg - PTR_ONE;
                                        state_next     = ST_BUSY;
                                    end else begin
                                        err_hit = 1'b1;
                                        err_sel = DAU_ERR_STACK_UNF;
                                    end
                                end else if (ptr_reg < PTR_MAX) begin
                                    lb_en_next     = 1'b1;
                                    lb_sym_next    = i_symbol;
                                    count_next     = '0;
                                    got_comma_next = 1'b0;
                                    got_sign_next  = 1'b0;
                                    ptr_next       = ptr_reg + PTR_ONE;
                                    sym_next       = DAU_SYM_SEPARATOR;
                                end else begin
                                    err_hit = 1'b1;
                                    err_sel = DAU_ERR_STACK_OVF;
                                end
                            end
                            DAU_SYM_RESULT: begin
                                if (ptr_reg == '0) begin
                                    err_hit = 1'b1;
                                    err_sel = DAU_ERR_STACK_UNF;
                                end else if (sym_reg == DAU_SYM_SEPARATOR) begin
                                    lb_en_next                       = 1'b1;
                                    lb_sym_next                      = i_symbol;
                                    op_start_next[DAU_OPSTART_PRINT] = 1'b1;
                                    ptr_next                         = ptr_reg - PTR_ONE;
                                    sym_next                         = DAU_SYM_RESULT;
                                    state_next                       = ST_BUSY;
                                end else begin
                                    err_hit = 1'b1;
                                end
                            end
                            DAU_SYM_RESET: begin
                                lb_en_next      = 1'b1;
                                lb_sym_next     = DAU_SYM_RESULT;
                                clr_issued_next = 1'b0;
                                state_next      = ST_CLEAR;
                            end
                            default: err_hit = 1'b1;
                        endcase
                    end
                end
            end
            ST_BUSY: begin
                if (i_operation_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // The slot is empty on entry, so the first CLR loads unconditionally.
                if (!clr_issued_reg) begin
                    instr_load      = 1'b1;
                    instr_data      = {BCDU_OP_CLR, ptr_reg, 8'h00};
                    clr_issued_next = 1'b1;
                end else if (o_instr_valid && i_instr_ready) begin
                    comma_clr_next = 1'b1;
                    sign_clr_next  = 1'b1;
                    if (ptr_reg == '0) begin
                        clr_issued_next = 1'b0;
                        state_next      = ST_FLUSH;
                    end else begin
                        ptr_next   = ptr_reg - PTR_ONE;
                        instr_load = 1'b1;
                        instr_data = {BCDU_OP_CLR, ptr_reg - PTR_ONE, 8'h00};
                    end
                end
            end
            ST_FLUSH: begin
                lb_en_next     = 1'b1;
                lb_sym_next    = DAU_SYM_NEW_LINE;
                count_next     = '0;
                got_comma_next = 1'b0;
                got_sign_next  = 1'b0;
                sym_next       = DAU_SYM_INVALID;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        err_next      = err_hit;
        err_code_next = err_hit ? err_sel : err_code_reg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            sym_reg        <= DAU_SYM_INVALID;
            count_reg      <= '0;
            got_comma_reg  <= 1'b0;
            got_sign_reg   <= 1'b0;
            ptr_reg        <= '0;
            clr_issued_reg <= 1'b0;
            lb_en_reg      <= 1'b0;
            lb_sym_reg     <= DAU_SYM_INVALID;
            op_start_reg   <= '0;
            comma_inc_reg  <= 1'b0;
            comma_clr_reg  <= 1'b0;
            sign_set_reg   <= 1'b0;
            sign_clr_reg   <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            sym_reg        <= sym_next;
            count_reg      <= count_next;
            got_comma_reg  <= got_comma_next;
            got_sign_reg   <= got_sign_next;
            ptr_reg        <= ptr_next;
            clr_issued_reg <= clr_issued_next;
            lb_en_reg      <= lb_en_next;
            lb_sym_reg     <= lb_sym_next;
            op_start_reg   <= op_start_next;
            comma_inc_reg  <= comma_inc_next;
            comma_clr_reg  <= comma_clr_next;
            sign_set_reg   <= sign_set_next;
            sign_clr_reg   <= sign_clr_next;
            err_reg        <= err_next;
            err_code_reg   <= err_code_next;
        end
    end

    assign o_op_start        = op_start_reg;
    assign o_loopback_en     = lb_en_reg;
    assign o_loopback_symbol = lb_sym_reg;
    assign o_comma_inc       = comma_inc_reg;
    assign o_comma_clr       = comma_clr_reg;
    assign o_sign_set        = sign_set_reg;
    assign o_sign_clr        = sign_clr_reg;
    assign o_stack_ptr       = ptr_reg;
    assign o_error           = err_reg;
    assign o_error_code      = err_code_reg;

endmodule

// File: tb/tb_dau_token_decoder.sv
// Directed bench for dau_token_decoder: operand entry, operations, errors,
// backpressure, stack clear and reset during clear.
module tb_dau_token_decoder;
    import dau_token_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [4:0]  i_symbol = DAU_SYM_INVALID;
    logic        o_ready;
    logic        o_instr_valid;
    logic [14:0] o_instr;
    logic        i_instr_ready = 1'b1;
    logic        i_operation_done = 1'b0;
    logic [4:0]  o_op_start;
    logic        o_loopback_en;
    logic [4:0]  o_loopback_symbol;
    logic        o_comma_inc, o_comma_clr, o_sign_set, o_sign_clr;
    logic [2:0]  o_stack_ptr;
    logic        o_error;
    logic [1:0]  o_error_code;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dau_token_decoder #(.NUM_DIGITS(8), .STACK_DEPTH(7)) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .i_symbol          (i_symbol),
        .o_ready           (o_ready),
        .o_instr_valid     (o_instr_valid),
        .o_instr           (o_instr),
        .i_instr_ready     (i_instr_ready),
        .i_operation_done  (i_operation_done),
        .o_op_start        (o_op_start),
        .o_loopback_en     (o_loopback_en),
        .o_loopback_symbol (o_loopback_symbol),
        .o_comma_inc       (o_comma_inc),
        .o_comma_clr       (o_comma_clr),
        .o_sign_set        (o_sign_set),
        .o_sign_clr        (o_sign_clr),
        .o_stack_ptr       (o_stack_ptr),
        .o_error           (o_error),
        .o_error_code      (o_error_code)
    );

    function automatic logic [14:0] mk(input logic [3:0] op, input logic [2:0] p, input logic [7:0] a);
        return {op, p, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-16s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a symbol, wait (bounded) for acceptance; returns on the falling
    // edge after the accepting rising edge so registered results are visible.
    task automatic send(input logic [4:0] s);
        int n;
        n = 0;
        i_valid  = 1'b1;
        i_symbol = s;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) check("send_timeout", 32'(o_ready), 32'd1);
        @(negedge clk);
        i_valid  = 1'b0;
        i_symbol = DAU_SYM_INVALID;
    endtask

    logic [14:0] clr_q[$];
    int          clr_pulses;
    bit          seen_nl;

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_ivalid", 32'(o_instr_valid), 32'd0);
        check("rst_instr", 32'(o_instr), 32'd0);
        check("rst_lbsym", 32'(o_loopback_symbol), 32'(DAU_SYM_INVALID));
        check("rst_ptr", 32'(o_stack_ptr), 32'd0);
        check("rst_err", 32'({o_error, o_error_code, o_op_start}), 32'd0);

        // "1" "2" "," "5" SEP "3" SEP "+" SEP
        send(5'd1);
        check("shl1", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd0, 8'hC1)));
        check("shl1_valid", 32'(o_instr_valid), 32'd1);
        check("echo1", 32'({o_loopback_en, o_loopback_symbol}), 32'({1'b1, 5'd1}));
        check("cinc1", 32'(o_comma_inc), 32'd0);
        send(5'd2);
        check("shl2", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd0, 8'hC2)));
        send(DAU_SYM_COMMA);
        check("comma_echo", 32'({o_loopback_en, o_loopback_symbol}), 32'({1'b1, DAU_SYM_COMMA}));
        check("comma_noinstr", 32'(o_instr_valid), 32'd0);
        send(5'd5);
        check("shl5", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd0, 8'hC5)));
        check("cinc5", 32'(o_comma_inc), 32'd1);
        send(DAU_SYM_SEPARATOR);
        check("ptr1", 32'(o_stack_ptr), 32'd1);
        send(5'd3);
        check("shl3", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd1, 8'hC3)));
        send(DAU_SYM_SEPARATOR);
        check("ptr2", 32'(o_stack_ptr), 32'd2);
        send(DAU_SYM_PLUS);
        check("plus_echo", 32'(o_loopback_symbol), 32'(DAU_SYM_PLUS));
        send(DAU_SYM_SEPARATOR);
        check("add_start", 32'(o_op_start), 32'b00010);
        check("add_ptr", 32'(o_stack_ptr), 32'd1);
        check("busy_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("busy_hold", 32'(o_ready), 32'd0);
        check("start_pulse", 32'(o_op_start), 32'd0);
        i_operation_done = 1'b1;
        @(negedge clk);
        i_operation_done = 1'b0;
        check("done_ready", 32'(o_ready), 32'd1);

        // Digit overflow: 9 digits into the operand at ptr 1
        for (int d = 0; d < 8; d++) send(5'd9);
        check("shl9_last", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd1, 8'hC9)));
        send(5'd9);
        check("dovf_err", 32'({o_error, o_error_code}), 32'({1'b1, DAU_ERR_DIGIT_OVF}));
        check("dovf_noecho", 32'(o_loopback_en), 32'd0);
        @(negedge clk);
        check("err_pulse", 32'(o_error), 32'd0);

        // Backpressure during digit entry
        send(DAU_SYM_SEPARATOR);
        check("ptr2b", 32'(o_stack_ptr), 32'd2);
        i_instr_ready = 1'b0;
        send(5'd4);
        check("shl4", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd2, 8'hC4)));
        i_valid  = 1'b1;
        i_symbol = 5'd6;
        for (int c = 0; c < 5; c++) @(negedge clk);
        check("bp_ready", 32'(o_ready), 32'd0);
        check("bp_instr", 32'({o_instr_valid, o_instr}), 32'({1'b1, mk(BCDU_OP_SHL, 3'd2, 8'hC4)}));
        i_instr_ready = 1'b1;
        @(negedge clk);
        i_valid  = 1'b0;
        i_symbol = DAU_SYM_INVALID;
        check("bp_shl6", 32'({o_instr_valid, o_instr}), 32'({1'b1, mk(BCDU_OP_SHL, 3'd2, 8'hC6)}));
        check("bp_echo6", 32'(o_loopback_symbol), 32'd6);

        // Stack clear with three operands
        send(DAU_SYM_SEPARATOR);
        check("ptr3", 32'(o_stack_ptr), 32'd3);
        send(DAU_SYM_RESET);
        check("reset_echo", 32'({o_loopback_en, o_loopback_symbol}), 32'({1'b1, DAU_SYM_RESULT}));
        seen_nl    = 1'b0;
        clr_pulses = 0;
        for (int c = 0; c < 60 && !seen_nl; c++) begin
            @(negedge clk);
            if (o_comma_clr) clr_pulses++;
            if (o_loopback_en && o_loopback_symbol == DAU_SYM_NEW_LINE) begin
                seen_nl = 1'b1;
            end else begin
                i_instr_ready = ~i_instr_ready;
                if (o_instr_valid && i_instr_ready) clr_q.push_back(o_instr);
            end
        end
        i_instr_ready = 1'b1;
        check("flush_nl", 32'(seen_nl), 32'd1);
        check("clr_count", 32'(clr_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("clr_idx%0d", 3 - k),
                  32'((k < clr_q.size()) ? clr_q[k] : 15'h7fff),
                  32'(mk(BCDU_OP_CLR, 3'(3 - k), 8'h00)));
        end
        check("clr_pulses", 32'(clr_pulses), 32'd4);
        check("clr_ptr", 32'(o_stack_ptr), 32'd0);
        check("clr_ready", 32'(o_ready), 32'd1);

        // Underflow on operator with a single operand
        send(5'd5);
        check("u_shl5", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd0, 8'hC5)));
        send(DAU_SYM_SEPARATOR);
        send(DAU_SYM_MUL);
        check("mul_echo", 32'(o_loopback_symbol), 32'(DAU_SYM_MUL));
        send(DAU_SYM_SEPARATOR);
        check("unf_err", 32'({o_error, o_error_code}), 32'({1'b1, DAU_ERR_STACK_UNF}));
        check("unf_nomul", 32'(o_op_start), 32'd0);
        check("unf_ptr", 32'(o_stack_ptr), 32'd1);
        send(5'd7);
        check("shl7", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd1, 8'hC7)));

        // Reset in the second cycle of CLEAR
        send(DAU_SYM_SEPARATOR);
        send(DAU_SYM_RESET);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mid_ready", 32'(o_ready), 32'd1);
        check("mid_instr", 32'({o_instr_valid, o_instr}), 32'd0);
        check("mid_ptr", 32'(o_stack_ptr), 32'd0);
        check("mid_lb", 32'({o_loopback_en, o_loopback_symbol}), 32'({1'b0, DAU_SYM_INVALID}));
        check("mid_pulses", 32'({o_comma_clr, o_sign_clr, o_error, o_error_code}), 32'd0);

        // Leading minus then digit sets the sign; double comma is a syntax error
        send(DAU_SYM_MINUS);
        check("minus_echo", 32'({o_loopback_en, o_loopback_symbol}), 32'({1'b1, DAU_SYM_MINUS}));
        send(5'd8);
        check("shl8", 32'(o_instr), 32'(mk(BCDU_OP_SHL, 3'd0, 8'hC8)));
        check("sign_set", 32'(o_sign_set), 32'd1);
        send(DAU_SYM_COMMA);
        check("comma_ok", 32'(o_error), 32'd0);
        send(DAU_SYM_COMMA);
        check("syn_err", 32'({o_error, o_error_code, o_loopback_en}), 32'({1'b1, DAU_ERR_SYNTAX, 1'b0}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
